// File: rtl/dspm_req_splitter.sv
// Scratchpad request splitter: folds the two-phase (index, then tag) load
// request into one single-cycle SPM request; stores pass straight through.
package dspm_pkg;
    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH   = 44;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;
endpackage

module dspm_req_splitter
    import dspm_pkg::*;
#(
    parameter int IDX_WIDTH = DCACHE_INDEX_WIDTH,
    parameter int TAG_WIDTH = DCACHE_TAG_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  dcache_req_i_t req_port_i,
    output dcache_req_o_t req_port_o,
    output dcache_req_i_t spm_req_o,
    input  dcache_req_o_t spm_req_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TAG,
        ISSUE,
        DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [7:0]           be_q, be_d;
    logic [1:0]           size_q, size_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
            be_q    <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            be_q    <= be_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        be_d       = be_q;
        size_d     = size_q;
        spm_req_o  = '0;
        req_port_o = '0;

        unique case (state_q)
            IDLE: begin
                if (req_port_i.data_req) begin
                    if (req_port_i.data_we) begin
                        spm_req_o           = req_port_i;
                        req_port_o.data_gnt = spm_req_i.data_gnt;
                    end else begin
                        req_port_o.data_gnt = 1'b1;
                        idx_d   = IDX_WIDTH'(req_port_i.address_index);
                        be_d    = req_port_i.data_be;
                        size_d  = req_port_i.data_size;
                        state_d = WAIT_TAG;
                    end
                end
            end
            WAIT_TAG: begin
                if (req_port_i.kill_req) begin
                    state_d = IDLE;
                end else if (req_port_i.tag_valid) begin
                    tag_d   = TAG_WIDTH'(req_port_i.address_tag);
                    state_d = ISSUE;
                end
            end
            ISSUE, DRAIN: begin
                // DRAIN keeps the request up so the SPM finishes cleanly
                spm_req_o.data_req      = 1'b1;
                spm_req_o.tag_valid     = 1'b1;
                spm_req_o.address_index = DCACHE_INDEX_WIDTH'(idx_q);
                spm_req_o.address_tag   = DCACHE_TAG_WIDTH'(tag_q);
                spm_req_o.data_be       = be_q;
                spm_req_o.data_size     = size_q;
                if (spm_req_i.data_rvalid) begin
                    state_d = IDLE;
                    if (state_q == ISSUE) begin
                        req_port_o.data_rvalid = 1'b1;
                        req_port_o.data_rdata  = spm_req_i.data_rdata;
                    end
                end else if (state_q == ISSUE && req_port_i.kill_req) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rst_ni) begin
            spm_req_o  = '0;
            req_port_o = '0;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_dspm_req_splitter.sv
// Bench for dspm_req_splitter: upstream transaction driver, SPM memory
// model with random latency, and an output monitor fed by expect queues.
module tb_dspm_req_splitter;
    import dspm_pkg::*;

    typedef struct packed {
        logic [11:0] idx;
        logic [43:0] tag;
        logic [7:0]  be;
        logic [63:0] wdata;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    dcache_req_i_t req_i;
    dcache_req_o_t req_o;
    dcache_req_i_t spm_o;
    dcache_req_o_t spm_i;
    dcache_req_o_t man;
    logic          busy;

    always #5 clk = ~clk;

    dspm_req_splitter dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_port_i(req_i),
        .req_port_o(req_o),
        .spm_req_o (spm_o),
        .spm_req_i (spm_i),
        .busy_o    (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [55:0] rd_q[$];
    wr_t         wr_q[$];
    int          lat_q[$];
    bit          resp_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // SPM contents as a pure function of the address
    function automatic logic [63:0] mem_f(input logic [43:0] t,
                                          input logic [11:0] i);
        return {t[31:0], 8'h5A, i, i}
             ^ ({52'h0, i} * 64'h9E3779B97F4A7C15)
             ^ {20'h0, t};
    endfunction

    // downstream SPM responder
    int cnt = 0;
    bit act = 1'b0;
    always @(posedge clk) begin
        #2;
        if (!resp_en) begin
            spm_i = man;
        end else begin
            spm_i = '0;
            if (spm_o.data_req && spm_o.data_we) begin
                spm_i.data_gnt = 1'($urandom_range(0, 1));
                act = 1'b0;
            end else if (spm_o.data_req) begin
                if (!act) begin
                    act = 1'b1;
                    cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                end
                if (cnt == 0) begin
                    spm_i.data_rvalid = 1'b1;
                    spm_i.data_rdata  = mem_f(spm_o.address_tag,
                                              spm_o.address_index);
                    act = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                act = 1'b0;
                if ($urandom_range(0, 5) == 0) begin
                    spm_i.data_rvalid = 1'b1;
                    spm_i.data_rdata  = {$urandom, $urandom};
                end
            end
        end
    end

    // monitor
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n) begin
            if (req_o.data_rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL up_rvalid: got rvalid data %0h, want none",
                             req_o.data_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("up_rdata", req_o.data_rdata, e);
                end
            end
            if (spm_o.data_req && spm_o.data_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dn_write: got write idx %0h, want none",
                             spm_o.address_index);
                end else begin
                    chk("dn_wr_fields",
                        {spm_o.address_index, spm_o.address_tag,
                         spm_o.data_be, spm_o.data_wdata}, wr_q[0]);
                    chk("wr_gnt", req_o.data_gnt, spm_i.data_gnt);
                    if (spm_i.data_gnt) void'(wr_q.pop_front());
                end
            end
            if (spm_o.data_req && !spm_o.data_we) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dn_read: got read idx %0h, want none",
                             spm_o.address_index);
                end else begin
                    chk("dn_rd_addr",
                        {spm_o.address_tag, spm_o.address_index}, rd_q[0]);
                    chk("dn_rd_wdata", spm_o.data_wdata, 0);
                    if (spm_i.data_rvalid) void'(rd_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            cyc();
            req_i = '0;
            smp();
            n++;
        end
        chk(nm, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind, d, rv, g;
        logic [11:0] idx;
        logic [43:0] tag;
        wr_t         w;

        req_i = '0;
        man   = '0;
        // reset: outputs gated even with live inputs
        req_i.data_req      = 1'b1;
        req_i.data_we       = 1'b1;
        req_i.address_index = 12'h055;
        man.data_gnt        = 1'b1;
        man.data_rvalid     = 1'b1;
        repeat (3) @(posedge clk);
        smp();
        chk("rst_spm_req", spm_o.data_req, 0);
        chk("rst_gnt", req_o.data_gnt, 0);
        chk("rst_rvalid", req_o.data_rvalid, 0);
        chk("rst_busy", busy, 0);
        cyc();
        req_i = '0;
        man   = '0;
        rst_n = 1'b1;
        smp();

        // nominal read timeline
        cyc();
        req_i = '0;
        req_i.data_req      = 1'b1;
        req_i.address_index = 12'h1A8;
        req_i.data_be       = 8'hFF;
        req_i.data_size     = 2'd3;
        smp();
        chk("t26_gnt", req_o.data_gnt, 1);
        chk("t26_busy0", busy, 0);
        cyc();
        req_i = '0;
        req_i.tag_valid   = 1'b1;
        req_i.address_tag = 44'h3;
        rd_q.push_back({44'h3, 12'h1A8});
        smp();
        chk("t26_busy1", busy, 1);
        chk("t26_noreq1", spm_o.data_req, 0);
        cyc();
        req_i = '0;
        smp();
        chk("t26_req2", spm_o.data_req, 1);
        chk("t26_be", spm_o.data_be, 8'hFF);
        cyc();
        man.data_rvalid = 1'b1;
        man.data_rdata  = 64'hDEADBEEF;
        exp_q.push_back(64'hDEADBEEF);
        smp();
        chk("t26_rvalid3", req_o.data_rvalid, 1);
        cyc();
        man = '0;
        smp();
        chk("t26_busy4", busy, 0);
        chk("t26_noreq4", spm_o.data_req, 0);

        // write passthrough
        cyc();
        req_i = '0;
        req_i.data_req      = 1'b1;
        req_i.data_we       = 1'b1;
        req_i.data_be       = 8'hFF;
        req_i.data_wdata    = 64'h1234;
        req_i.address_index = 12'h0F0;
        req_i.address_tag   = 44'h777;
        w = '{idx: 12'h0F0, tag: 44'h777, be: 8'hFF, wdata: 64'h1234};
        wr_q.push_back(w);
        smp();
        chk("t27_gnt0", req_o.data_gnt, 0);
        chk("t27_wdata", spm_o.data_wdata, 64'h1234);
        chk("t27_busy", busy, 0);
        cyc();
        man.data_gnt = 1'b1;
        smp();
        chk("t27_gnt1", req_o.data_gnt, 1);
        cyc();
        req_i = '0;
        man   = '0;
        smp();
        chk("t27_idle", busy, 0);

        // kill while waiting for the tag
        cyc();
        req_i = '0;
        req_i.data_req      = 1'b1;
        req_i.address_index = 12'h010;
        smp();
        chk("t28_gnt", req_o.data_gnt, 1);
        cyc();
        req_i = '0;
        req_i.kill_req    = 1'b1;
        req_i.tag_valid   = 1'b1;
        req_i.address_tag = 44'h5;
        smp();
        chk("t28_noreq", spm_o.data_req, 0);
        cyc();
        req_i = '0;
        smp();
        chk("t28_idle", busy, 0);
        chk("t28_noreq2", spm_o.data_req, 0);

        // kill while issued: response drained
        cyc();
        req_i = '0;
        req_i.data_req      = 1'b1;
        req_i.address_index = 12'h2C4;
        smp();
        cyc();
        req_i = '0;
        req_i.tag_valid   = 1'b1;
        req_i.address_tag = 44'h9;
        rd_q.push_back({44'h9, 12'h2C4});
        smp();
        cyc();
        req_i = '0;
        req_i.kill_req = 1'b1;
        smp();
        chk("t29_req_issue", spm_o.data_req, 1);
        cyc();
        req_i = '0;
        smp();
        chk("t29_req_held", spm_o.data_req, 1);
        chk("t29_busy", busy, 1);
        cyc();
        man.data_rvalid = 1'b1;
        man.data_rdata  = 64'hCA11AB1EBADCAB1E;
        smp();
        chk("t29_no_rvalid", req_o.data_rvalid, 0);
        cyc();
        man = '0;
        smp();
        chk("t29_idle", busy, 0);

        // reset pulse mid-transaction
        cyc();
        req_i = '0;
        req_i.data_req      = 1'b1;
        req_i.address_index = 12'h3FF;
        smp();
        cyc();
        req_i = '0;
        req_i.tag_valid   = 1'b1;
        req_i.address_tag = 44'h1;
        rd_q.push_back({44'h1, 12'h3FF});
        smp();
        cyc();
        req_i = '0;
        smp();
        chk("t30_req_before", spm_o.data_req, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t30_async_req", spm_o.data_req, 0);
        chk("t30_busy", busy, 0);
        #1 rst_n = 1'b1;
        rd_q.delete();
        cyc();
        man.data_rvalid = 1'b1;
        man.data_rdata  = 64'h1A7E;
        smp();
        chk("t30_late", req_o.data_rvalid, 0);
        cyc();
        man = '0;
        smp();

        // back-to-back reads with the second request held high
        cyc();
        resp_en = 1'b1;
        req_i = '0;
        req_i.data_req      = 1'b1;
        req_i.address_index = 12'h111;
        smp();
        chk("t31_gnt_a", req_o.data_gnt, 1);
        cyc();
        req_i = '0;
        req_i.data_req      = 1'b1;
        req_i.address_index = 12'h222;
        req_i.tag_valid     = 1'b1;
        req_i.address_tag   = 44'hA;
        rd_q.push_back({44'hA, 12'h111});
        exp_q.push_back(mem_f(44'hA, 12'h111));
        lat_q.push_back(1);
        rv = -1;
        g  = -1;
        for (int c = 1; c < 30 && g < 0; c++) begin
            if (c > 1) begin
                cyc();
                req_i = '0;
                req_i.data_req      = 1'b1;
                req_i.address_index = 12'h222;
            end
            smp();
            if (req_o.data_rvalid) rv = c;
            if (req_o.data_gnt) g = c;
        end
        chk("t31_rv_seen", (rv >= 0), 1);
        chk("t31_gap", 32'(g - rv), 1);
        cyc();
        req_i = '0;
        req_i.tag_valid   = 1'b1;
        req_i.address_tag = 44'hB;
        rd_q.push_back({44'hB, 12'h222});
        exp_q.push_back(mem_f(44'hB, 12'h222));
        lat_q.push_back(0);
        smp();
        wait_idle("t31_done");

        // randomised traffic
        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 3);
            idx  = 12'($urandom);
            tag  = 44'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                cyc();
                req_i = '0;
                smp();
            end
            cyc();
            req_i = '0;
            req_i.data_req      = 1'b1;
            req_i.data_we       = (kind == 0);
            req_i.address_index = idx;
            req_i.address_tag   = tag;
            req_i.data_be       = 8'($urandom);
            req_i.data_size     = 2'($urandom);
            if (kind == 0) begin
                req_i.data_wdata = {$urandom, $urandom};
                w = '{idx: idx, tag: tag, be: req_i.data_be,
                      wdata: req_i.data_wdata};
                wr_q.push_back(w);
                d = 0;
                smp();
                while (!req_o.data_gnt && d < 20) begin
                    cyc();
                    smp();
                    d++;
                end
                chk("wr_hs", req_o.data_gnt, 1);
            end else begin
                smp();
                chk("rd_gnt", req_o.data_gnt, 1);
                d = $urandom_range(0, 3);
                repeat (d) begin
                    cyc();
                    req_i = '0;
                    req_i.address_index = 12'($urandom);
                    smp();
                end
                cyc();
                req_i = '0;
                req_i.address_tag = tag;
                if (kind == 2) begin
                    req_i.kill_req  = 1'b1;
                    req_i.tag_valid = 1'($urandom_range(0, 1));
                end else begin
                    req_i.tag_valid = 1'b1;
                    rd_q.push_back({tag, idx});
                    if (kind == 3) begin
                        lat_q.push_back($urandom_range(1, 3));
                    end else begin
                        lat_q.push_back($urandom_range(0, 3));
                        exp_q.push_back(mem_f(tag, idx));
                    end
                end
                smp();
                if (kind == 3) begin
                    cyc();
                    req_i = '0;
                    req_i.kill_req = 1'b1;
                    smp();
                end
                wait_idle(kind == 2 ? "kill_wt_idle" : "rd_done");
            end
        end

        cyc();
        req_i = '0;
        smp();
        chk("exp_q_empty", exp_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
